// File: rtl/spu_adsr_engine.sv
// Time-multiplexed ADSR envelope engine: per-voice volume/phase/countdown storage,
// one voice advanced per update strobe, result registered one cycle later.
module spu_adsr_engine #(
    parameter int NVOICES = 24,
    parameter int VOL_W   = 15,
    parameter int CYC_W   = 23,
    parameter int VIDX_W  = 5
) (
    input  logic              i_clk,
    input  logic              n_rst,
    input  logic              i_spu_enable,
    input  logic              i_upd_valid,
    input  logic [VIDX_W-1:0] i_upd_voice,
    input  logic              i_kon,
    input  logic              i_koff,
    input  logic [15:0]       i_adsr_lo,
    input  logic [15:0]       i_adsr_hi,
    input  logic              i_host_wr,
    input  logic [VIDX_W-1:0] i_host_voice,
    input  logic [VOL_W-1:0]  i_host_vol,
    output logic              o_res_valid,
    output logic [VIDX_W-1:0] o_res_voice,
    output logic [VOL_W-1:0]  o_res_vol,
    output logic [1:0]        o_res_state,
    output logic              o_voice_end
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } adsr_state_e;

    // Signed step width: room for the largest delta (8 << 11) plus two guard bits.
    localparam int SW = ((VOL_W > 15) ? VOL_W : 15) + 2;
    localparam int PW = SW + VOL_W + 1;
    localparam logic [VOL_W-1:0] VOL_MAX  = {VOL_W{1'b1}};
    localparam logic [VOL_W-1:0] VOL_KNEE = VOL_W'(3 << (VOL_W - 2));
    localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

    logic [VOL_W-1:0] vol_q   [NVOICES];
    logic [VOL_W-1:0] vol_d   [NVOICES];
    adsr_state_e      state_q [NVOICES];
    adsr_state_e      state_d [NVOICES];
    logic [CYC_W-1:0] cyc_q   [NVOICES];
    logic [CYC_W-1:0] cyc_d   [NVOICES];

    logic              res_valid_q, res_valid_d;
    logic [VIDX_W-1:0] res_voice_q, res_voice_d;
    logic [VOL_W-1:0]  res_vol_q,   res_vol_d;
    adsr_state_e       res_state_q, res_state_d;
    logic              res_end_q,   res_end_d;

    logic upd_ok, host_ok;
    assign upd_ok  = i_upd_valid && (int'(i_upd_voice) < NVOICES);
    assign host_ok = i_host_wr && (int'(i_host_voice) < NVOICES);

    logic [VOL_W-1:0] cur_vol;
    adsr_state_e      cur_st;
    logic [CYC_W-1:0] cur_cyc;
    assign cur_vol = vol_q[i_upd_voice];
    assign cur_st  = state_q[i_upd_voice];
    assign cur_cyc = cyc_q[i_upd_voice];

    logic                 exp_mode, decr;
    logic [4:0]           shift, dsh, csh;
    logic signed [3:0]    stepval;
    logic signed [SW-1:0] delta_lin, delta, sum;
    logic signed [PW-1:0] prod, prod_sh;
    logic [31:0]          cyc_base;
    logic [CYC_W-1:0]     cyc_reload;
    logic [SW-1:0]        sus_thr;
    logic [VOL_W-1:0]     step_vol;
    adsr_state_e          step_st;

    always_comb begin : p_step
        exp_mode = 1'b0;
        decr     = 1'b1;
        shift    = '0;
        stepval  = 4'sb1000;
        case (cur_st)
            ST_ATTACK: begin
                exp_mode = i_adsr_lo[15];
                decr     = 1'b0;
                shift    = i_adsr_lo[14:10];
                stepval  = $signed(4'd7 - {2'b00, i_adsr_lo[9:8]});
            end
            ST_DECAY: begin
                exp_mode = 1'b1;
                shift    = {1'b0, i_adsr_lo[7:4]};
            end
            ST_SUSTAIN: begin
                exp_mode = i_adsr_hi[15];
                decr     = i_adsr_hi[14];
                shift    = i_adsr_hi[12:8];
                stepval  = i_adsr_hi[14] ? $signed(4'b1000 + {2'b00, i_adsr_hi[7:6]})
                                         : $signed(4'd7 - {2'b00, i_adsr_hi[7:6]});
            end
            default: begin
                exp_mode = i_adsr_hi[5];
                shift    = i_adsr_hi[4:0];
            end
        endcase

        dsh       = (shift < 5'd11) ? 5'd11 - shift : 5'd0;
        csh       = (shift > 5'd11) ? shift - 5'd11 : 5'd0;
        delta_lin = $signed({{(SW-4){stepval[3]}}, stepval}) <<< dsh;
        // Exponential decay scales the step by the current level (floor via >>>).
        prod      = $signed({{(PW-SW){delta_lin[SW-1]}}, delta_lin})
                  * $signed({{(PW-VOL_W){1'b0}}, cur_vol});
        prod_sh   = prod >>> VOL_W;
        delta     = (exp_mode && decr) ? $signed(prod_sh[SW-1:0]) : delta_lin;
        sum       = $signed({{(SW-VOL_W){1'b0}}, cur_vol}) + delta;

        if (sum[SW-1])
            step_vol = '0;
        else if (sum > $signed({{(SW-VOL_W){1'b0}}, VOL_MAX}))
            step_vol = VOL_MAX;
        else
            step_vol = sum[VOL_W-1:0];

        cyc_base = 32'd1 << csh;
        if (exp_mode && !decr && (cur_vol > VOL_KNEE))
            cyc_base = cyc_base << 2;
        cyc_reload = (cyc_base > 32'(CYC_MAX)) ? CYC_MAX : cyc_base[CYC_W-1:0];

        sus_thr = ({{(SW-4){1'b0}}, i_adsr_lo[3:0]} + SW'(1)) << (VOL_W - 4);
        step_st = cur_st;
        if ((cur_st == ST_ATTACK) && (step_vol == VOL_MAX))
            step_st = ST_DECAY;
        else if ((cur_st == ST_DECAY) && ({{(SW-VOL_W){1'b0}}, step_vol} <= sus_thr))
            step_st = ST_SUSTAIN;
    end

    logic [VOL_W-1:0] nxt_vol;
    adsr_state_e      nxt_st;
    logic [CYC_W-1:0] nxt_cyc;
    logic             nxt_end;

    always_comb begin : p_event
        nxt_vol = cur_vol;
        nxt_st  = cur_st;
        nxt_cyc = cur_cyc;
        nxt_end = 1'b0;
        if (!i_spu_enable) begin
            nxt_vol = '0;
        end else if (i_kon) begin
            nxt_vol = '0;
            nxt_st  = ST_ATTACK;
            nxt_cyc = CYC_ONE;
        end else if (i_koff) begin
            nxt_st  = ST_RELEASE;
            nxt_cyc = CYC_ONE;
        end else if (cur_cyc > CYC_ONE) begin
            nxt_cyc = cur_cyc - CYC_ONE;
        end else begin
            nxt_vol = step_vol;
            nxt_st  = step_st;
            nxt_cyc = cyc_reload;
            nxt_end = (cur_st == ST_RELEASE) && (cur_vol != '0) && (step_vol == '0);
        end
    end

    always_comb begin : p_store
        vol_d   = vol_q;
        state_d = state_q;
        cyc_d   = cyc_q;
        if (upd_ok) begin
            vol_d[i_upd_voice]   = nxt_vol;
            state_d[i_upd_voice] = nxt_st;
            cyc_d[i_upd_voice]   = nxt_cyc;
        end
        // Host volume wins the storage slot; the result still reports the computed value.
        if (host_ok)
            vol_d[i_host_voice] = i_host_vol;
        res_valid_d = upd_ok;
        res_voice_d = upd_ok ? i_upd_voice : '0;
        res_vol_d   = upd_ok ? nxt_vol : '0;
        res_state_d = upd_ok ? nxt_st : ST_ATTACK;
        res_end_d   = upd_ok && nxt_end;
    end

    always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NVOICES; i++) begin
                vol_q[i]   <= '0;
                state_q[i] <= ST_RELEASE;
                cyc_q[i]   <= CYC_ONE;
            end
            res_valid_q <= 1'b0;
            res_voice_q <= '0;
            res_vol_q   <= '0;
            res_state_q <= ST_ATTACK;
            res_end_q   <= 1'b0;
        end else begin
            vol_q       <= vol_d;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            res_valid_q <= res_valid_d;
            res_voice_q <= res_voice_d;
            res_vol_q   <= res_vol_d;
            res_state_q <= res_state_d;
            res_end_q   <= res_end_d;
        end
    end

    assign o_res_valid = res_valid_q;
    assign o_res_voice = res_voice_q;
    assign o_res_vol   = res_vol_q;
    assign o_res_state = res_state_q;
    assign o_voice_end = res_end_q;

    logic unused_bits;
    assign unused_bits = ^{i_adsr_hi[13], prod_sh[PW-1:SW]};

endmodule

// File: tb/tb_spu_adsr_engine.sv
// Bench for spu_adsr_engine: directed plan scenarios plus randomized updates checked
// against an integer-arithmetic envelope model.
module tb_spu_adsr_engine;
    localparam int NV = 24;
    localparam int VW = 15;
    localparam int CW = 23;
    localparam int IW = 5;
    localparam int VMAX = (1 << VW) - 1;
    localparam int CMAX = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_spu_enable, i_upd_valid, i_kon, i_koff, i_host_wr;
    logic [IW-1:0] i_upd_voice, i_host_voice;
    logic [15:0]   i_adsr_lo, i_adsr_hi;
    logic [VW-1:0] i_host_vol;
    logic          o_res_valid, o_voice_end;
    logic [IW-1:0] o_res_voice;
    logic [VW-1:0] o_res_vol;
    logic [1:0]    o_res_state;

    spu_adsr_engine #(.NVOICES(NV), .VOL_W(VW), .CYC_W(CW), .VIDX_W(IW)) dut (
        .i_clk(i_clk), .n_rst(n_rst), .i_spu_enable(i_spu_enable),
        .i_upd_valid(i_upd_valid), .i_upd_voice(i_upd_voice), .i_kon(i_kon), .i_koff(i_koff),
        .i_adsr_lo(i_adsr_lo), .i_adsr_hi(i_adsr_hi), .i_host_wr(i_host_wr),
        .i_host_voice(i_host_voice), .i_host_vol(i_host_vol), .o_res_valid(o_res_valid),
        .o_res_voice(o_res_voice), .o_res_vol(o_res_vol), .o_res_state(o_res_state),
        .o_voice_end(o_voice_end)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int m_vol [NV];
    int m_st  [NV];
    int m_cyc [NV];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_vol[i] = 0;
            m_st[i]  = 3;
            m_cyc[i] = 1;
        end
    endtask

    // Envelope rules in plain arithmetic: phase 0 attack .. 3 release.
    task automatic model_upd(input int v, input bit en, input bit kon, input bit koff,
                             input logic [15:0] lo, input logic [15:0] hi,
                             output int rvol, output int rst, output int rend);
        int vol, st, cyc, sh, sv, c, nv;
        bit ex, dec;
        longint d;
        vol = m_vol[v]; st = m_st[v]; cyc = m_cyc[v]; rend = 0;
        if (!en) vol = 0;
        else if (kon) begin vol = 0; st = 0; cyc = 1; end
        else if (koff) begin st = 3; cyc = 1; end
        else if (cyc > 1) cyc = cyc - 1;
        else begin
            case (st)
                0: begin ex = lo[15]; dec = 0; sh = int'(lo[14:10]); sv = 7 - int'(lo[9:8]); end
                1: begin ex = 1; dec = 1; sh = int'(lo[7:4]); sv = -8; end
                2: begin
                    ex = hi[15]; dec = hi[14]; sh = int'(hi[12:8]);
                    sv = dec ? (-8 + int'(hi[7:6])) : (7 - int'(hi[7:6]));
                end
                default: begin ex = hi[5]; dec = 1; sh = int'(hi[4:0]); sv = -8; end
            endcase
            c = 1 << ((sh > 11) ? sh - 11 : 0);
            d = longint'(sv) * longint'(1 << ((sh < 11) ? 11 - sh : 0));
            if (ex && !dec && vol > 'h6000) c = c * 4;
            if (ex && dec) d = (d * vol) >>> VW;
            if (c > CMAX) c = CMAX;
            nv = vol + int'(d);
            if (nv < 0) nv = 0;
            if (nv > VMAX) nv = VMAX;
            if (st == 3 && vol != 0 && nv == 0) rend = 1;
            if (st == 0 && nv == VMAX) st = 1;
            else if (st == 1 && nv <= (int'(lo[3:0]) + 1) * (1 << (VW - 4))) st = 2;
            vol = nv; cyc = c;
        end
        m_vol[v] = vol; m_st[v] = st; m_cyc[v] = cyc;
        rvol = vol; rst = st;
    endtask

    task automatic upd(input int v, input bit en, input bit kon, input bit koff,
                       input logic [15:0] lo, input logic [15:0] hi,
                       input bit hw, input int hv, input int hval);
        int evol, est, eend;
        bit ev;
        evol = 0; est = 0; eend = 0;
        i_upd_valid = 1'b1; i_upd_voice = IW'(v); i_spu_enable = en;
        i_kon = kon; i_koff = koff; i_adsr_lo = lo; i_adsr_hi = hi;
        i_host_wr = hw; i_host_voice = IW'(hv); i_host_vol = VW'(hval);
        ev = (v < NV);
        if (ev) model_upd(v, en, kon, koff, lo, hi, evol, est, eend);
        if (hw && hv < NV) m_vol[hv] = hval;
        @(posedge i_clk);
        @(negedge i_clk);
        i_upd_valid = 1'b0; i_host_wr = 1'b0; i_kon = 1'b0; i_koff = 1'b0;
        chk("res_valid", o_res_valid, ev);
        if (ev) begin
            chk("res_voice", o_res_voice, v);
            chk("res_vol", o_res_vol, evol);
            chk("res_state", o_res_state, est);
            chk("voice_end", o_voice_end, eend);
        end
    endtask

    initial begin
        int v, hv, hval;
        bit en, kon, koff, hw;
        logic [15:0] lo, hi;
        i_spu_enable = 1'b1; i_upd_valid = 1'b0; i_upd_voice = '0; i_kon = 1'b0; i_koff = 1'b0;
        i_adsr_lo = '0; i_adsr_hi = '0; i_host_wr = 1'b0; i_host_voice = '0; i_host_vol = '0;
        model_reset();
        repeat (2) @(negedge i_clk);
        chk("rst_valid", o_res_valid, 0);
        chk("rst_vol", o_res_vol, 0);
        chk("rst_state", o_res_state, 0);
        chk("rst_end", o_voice_end, 0);
        n_rst = 1'b1;
        @(negedge i_clk);

        upd(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t1_vol", o_res_vol, 0);
        chk("t1_state", o_res_state, 3);

        upd(3, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t2_kon_state", o_res_state, 0);
        upd(3, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t2_vol1", o_res_vol, 'h3800);
        upd(3, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t2_vol2", o_res_vol, 'h7000);
        upd(3, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t2_vol3", o_res_vol, 'h7FFF);
        chk("t2_decay", o_res_state, 1);

        upd(3, 1, 0, 0, 16'h0007, 16'h0000, 0, 0, 0);
        chk("t3_vol", o_res_vol, 'h3FFF);
        chk("t3_sustain", o_res_state, 2);

        upd(5, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t4_konkoff_state", o_res_state, 0);
        upd(5, 1, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t4_koff_state", o_res_state, 3);

        upd(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 5, 'h1000);
        upd(5, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t5_vol", o_res_vol, 0);
        chk("t5_end", o_voice_end, 1);
        upd(5, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t5_end_once", o_voice_end, 0);

        upd(7, 1, 0, 0, 16'h0000, 16'h000B, 1, 7, 'h1234);
        chk("t6_collide_vol", o_res_vol, 0);
        upd(7, 1, 0, 0, 16'h0000, 16'h000B, 0, 0, 0);
        chk("t6_host_step", o_res_vol, 'h122C);
        upd(7, 0, 0, 0, 16'h0000, 16'h000B, 0, 0, 0);
        chk("t6_disable_vol", o_res_vol, 0);

        upd(27, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

        for (int n = 0; n < 700; n++) begin
            v    = ($urandom_range(0, 19) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 5));
            en   = ($urandom_range(0, 15) != 0);
            kon  = ($urandom_range(0, 11) == 0);
            koff = ($urandom_range(0, 11) == 0);
            lo   = 16'($urandom);
            hi   = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                lo[14:12] = 3'b000; lo[7:6] = 2'b00; hi[12:10] = 3'b000; hi[4:2] = 3'b000;
            end
            hw   = ($urandom_range(0, 5) == 0);
            hv   = int'($urandom_range(0, 7));
            hval = int'($urandom_range(0, VMAX));
            upd(v, en, kon, koff, lo, hi, hw, hv, hval);
        end

        i_upd_valid = 1'b1; i_upd_voice = IW'(2); i_spu_enable = 1'b1;
        @(posedge i_clk);
        #1 n_rst = 1'b0;
        #1 chk("mid_rst_valid", o_res_valid, 0);
        i_upd_valid = 1'b0;
        model_reset();
        @(negedge i_clk);
        n_rst = 1'b1;
        @(negedge i_clk);
        upd(2, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
